// File: rtl/cnn_window_gen_pkg.sv
// Shared constants for the sliding-window generator: window geometry,
// kernel one-hot codes and the kernel-code decoder.
package cnn_window_gen_pkg;

  localparam int WINDOW_SIZE = 9;
  localparam int KERNEL_SIZE = 3;
  localparam int IMG_DIM_W   = 8;

  localparam logic [KERNEL_SIZE-1:0] KCODE_1 = 3'b001;
  localparam logic [KERNEL_SIZE-1:0] KCODE_2 = 3'b010;
  localparam logic [KERNEL_SIZE-1:0] KCODE_3 = 3'b100;

  // Highest set bit wins, so a malformed code never yields a zero-sized kernel.
  function automatic logic [1:0] decode_kernel(input logic [KERNEL_SIZE-1:0] code);
    logic [1:0] k;
    k = 2'd1;
    if ((code & KCODE_3) != '0) begin
      k = 2'd3;
    end else if ((code & KCODE_2) != '0) begin
      k = 2'd2;
    end
    return k;
  endfunction

endpackage

// File: rtl/cnn_window_gen_line_buffer.sv
// One image line of pixel storage: synchronous write, read at the same
// address in the same cycle, so a read returns the value before the write.
module cnn_line_buffer
  import cnn_window_gen_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/cnn_window_gen.sv
// Raster-stream sliding-window generator: two chained line buffers plus a
// column history form a 3x3 neighbourhood; a strided K_h x K_w window is emitted.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int MAX_IMG_W = 64,
  parameter int DATA_W    = 32,
  parameter int WIN_SZ    = WINDOW_SIZE,
  parameter int DIM_W     = IMG_DIM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     conf_refresh,
  input  logic [DIM_W-1:0]         img_width,
  input  logic [DIM_W-1:0]         img_height,
  input  logic [KERNEL_SIZE-1:0]   kernel_height,
  input  logic [KERNEL_SIZE-1:0]   kernel_width,
  input  logic [DIM_W-1:0]         stride,
  input  logic                     pixel_valid,
  input  logic [DATA_W-1:0]        pixel_data,
  output logic                     pixel_ready,
  input  logic                     window_stall,
  output logic                     window_valid,
  output logic [WIN_SZ*DATA_W-1:0] window,
  output logic                     frame_done
);

  localparam int ADDR_W = $clog2(MAX_IMG_W);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] cfg_width, cfg_height, cfg_stride;
  logic [1:0]       cfg_kh, cfg_kw;
  logic [DIM_W-1:0] col, row, col_phase, row_phase;
  logic [DIM_W-1:0] kh_ext, kw_ext;
  logic             accept, col_last, row_last, col_gate, row_gate, emit;

  logic [DATA_W-1:0] lb_in  [2];
  logic [DATA_W-1:0] lb_out [2];
  logic [DATA_W-1:0] hist   [3][2];
  logic [DATA_W-1:0] cols   [3][3];
  logic [WIN_SZ*DATA_W-1:0] win_next;

  assign pixel_ready = ~conf_refresh & ~(window_valid & window_stall);
  assign accept      = pixel_valid & pixel_ready;

  assign kh_ext   = DIM_W'(cfg_kh);
  assign kw_ext   = DIM_W'(cfg_kw);
  assign col_last = (col == cfg_width - ONE);
  assign row_last = (row == cfg_height - ONE);
  assign col_gate = (col >= kw_ext - ONE);
  assign row_gate = (row >= kh_ext - ONE);
  assign emit     = accept & row_gate & col_gate & (row_phase == '0) & (col_phase == '0);

  // lb_out[0] is the previous row, lb_out[1] the row before that.
  assign lb_in[0] = pixel_data;
  assign lb_in[1] = lb_out[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      cnn_line_buffer #(
        .DEPTH  (MAX_IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_line (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col[ADDR_W-1:0]),
        .wr_data (lb_in[gi]),
        .rd_data (lb_out[gi])
      );
    end
  endgenerate

  // Neighbourhood as it stands after the current accept; row 0 is oldest.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      cols[r][0] = hist[r][0];
      cols[r][1] = hist[r][1];
    end
    cols[0][2] = lb_out[1];
    cols[1][2] = lb_out[0];
    cols[2][2] = pixel_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        hist[r][0] <= cols[r][1];
        hist[r][1] <= cols[r][2];
      end
    end
  end

  // Pack the bottom-right K_h x K_w block; unused elements stay zero.
  always_comb begin
    int kh_i, kw_i;
    kh_i = int'(cfg_kh);
    kw_i = int'(cfg_kw);
    win_next = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (r < kh_i && c < kw_i) begin
          win_next[(r*kw_i + c)*DATA_W +: DATA_W] = cols[3 - kh_i + r][3 - kw_i + c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_width    <= ONE;
      cfg_height   <= ONE;
      cfg_stride   <= ONE;
      cfg_kh       <= 2'd1;
      cfg_kw       <= 2'd1;
      col          <= '0;
      row          <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      window       <= '0;
      frame_done   <= 1'b0;
    end else if (conf_refresh) begin
      cfg_width    <= img_width;
      cfg_height   <= img_height;
      cfg_stride   <= stride;
      cfg_kh       <= decode_kernel(kernel_height);
      cfg_kw       <= decode_kernel(kernel_width);
      col          <= '0;
      row          <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= accept & col_last & row_last;
      if (accept) begin
        window_valid <= emit;
        if (emit) begin
          window <= win_next;
        end
        if (col_last) begin
          col       <= '0;
          col_phase <= '0;
          if (row_last) begin
            row       <= '0;
            row_phase <= '0;
          end else begin
            row <= row + ONE;
            if (row_gate) begin
              row_phase <= (row_phase == cfg_stride - ONE) ? '0 : row_phase + ONE;
            end
          end
        end else begin
          col <= col + ONE;
          if (col_gate) begin
            col_phase <= (col_phase == cfg_stride - ONE) ? '0 : col_phase + ONE;
          end
        end
      end else if (!window_stall) begin
        window_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Streaming sliding-window generator that sits directly upstream of the pooling stage and drives its window_valid/window inputs.
- Accepts a raster-order pixel stream (row-major, one 32-bit pixel per beat) and buffers the previous kernel rows in line buffers.
- Emits one K_h x K_w window per output position, honouring stride.
- Backpressure comes from the pool's window_stall.

Parameters:
- MAX_IMG_W, 64, maximum supported image width in pixels (line buffer depth).
- DATA_W, 32, pixel width.
- WIN_SZ, `WINDOW_SIZE (9), number of window elements (3x3 maximum).
- DIM_W, 8, width of image dimension and stride config fields.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- conf_refresh  in  1  loads configuration and restarts the frame.
- img_width  in  DIM_W  image width in pixels, 1..MAX_IMG_W.
- img_height  in  DIM_W  image height in rows, >=1.
- kernel_height  in  `KERNEL_SIZE  one-hot code: bit0=1, bit1=2, bit2=3 rows.
- kernel_width  in  `KERNEL_SIZE  one-hot code, same encoding as kernel_height.
- stride  in  DIM_W  window step in both dimensions, >=1.
- pixel_valid  in  1  input pixel present.
- pixel_data  in  DATA_W  input pixel.
- pixel_ready  out  1  pixel is accepted when pixel_valid & pixel_ready.
- window_stall  in  1  downstream cannot take a new window this cycle.
- window_valid  out  1  window holds a valid window.
- window  out  WIN_SZ*DATA_W  element r*K_w+c sits at bits [(r*K_w+c)*32 +: 32]; r=0 is the oldest row, c=0 the leftmost column. Elements >= K_h*K_w are 0.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=0, async):
  - row/col counters, row/col stride phase counters, window_valid, window and frame_done go to 0.
  - Config registers go to 1x1 kernel, stride 1, width 1, height 1.
  - Line buffer contents are don't-care.
- conf_refresh (sync): latches all config fields, decodes the one-hot kernel codes to K_h/K_w (1..3), clears all counters and window_valid.
  - pixel_ready=0 during that cycle; a pixel offered in that cycle is not consumed.
  - Config inputs are ignored when conf_refresh=0.
- pixel_ready = ~conf_refresh & ~(window_valid & window_stall).
- Accept cycle (pixel_valid & pixel_ready):
  - The 3x3 shift-register window shifts left one column.
  - The new right column = {line_buf1[col], line_buf0[col], pixel_data}, oldest row first.
  - line_buf1[col] <= line_buf0[col]; line_buf0[col] <= pixel_data.
  - col increments; on col==img_width-1, col wraps to 0 and row increments.
  - On the last pixel (row==img_height-1, col==img_width-1), row wraps to 0 and frame_done pulses in the next cycle.
- Window emission, registered; latency 1 cycle from the completing accept:
  - window_valid <= accept & row>=K_h-1 & col>=K_w-1 & row_phase==0 & col_phase==0.
  - col_phase counts 0..stride-1, starting at 0 when col==K_w-1, and resets at each row wrap.
  - row_phase behaves the same way against row==K_h-1 and resets at frame wrap.
  - Only the bottom-right K_h x K_w sub-block of the 3x3 shift register is packed onto window.
- Hold:
  - While window_valid & window_stall, window and window_valid are frozen and no pixel is accepted.
  - window_valid deasserts on the next cycle with no qualifying accept.
- Rows with row<K_h-1 still write the line buffers; stale columns from a previous row never appear in a valid window because of the col>=K_w-1 gate.
- Edge case: img_width<K_w or img_height<K_h produces no windows; frame_done still pulses.
- Reset asserted mid-frame discards the partial frame; the next frame starts at row 0, col 0.

Decomposition:
- Shared package/header (CNNConfig.vh) holds:
  - `WINDOW_SIZE and `KERNEL_SIZE.
  - A new `IMG_DIM_W.
  - Kernel one-hot code constants `KCODE_1/2/3.
- Sub-module cnn_line_buffer: one depth-MAX_IMG_W x DATA_W line with a synchronous write, read at the same address and a write-enable.
  - Two instances, chained.
  - Read-before-write at the same address.

Test Plan:
1. 4x4 image, pixels 0..15, kernel 3x3 (code 3'b100), stride 1, no stall -> 4 windows. First window is {0,1,2,4,5,6,8,9,10} one cycle after pixel 10 is accepted; last is {5,6,7,9,10,11,13,14,15}; frame_done pulses once after pixel 15.
2. 4x4 image, kernel 2x2, stride 2 -> exactly 4 windows: {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}; elements 4..8 are 0.
3. Same as 1 with window_stall=1 for 3 cycles when the first window appears -> window holds {0,1,2,4,5,6,8,9,10}, pixel_ready=0 for those 3 cycles, and no pixel is lost; the 4 windows are still correct.
4. Back-to-back frames of the same 4x4/3x3 config -> the second frame yields identical windows; no row from frame 1 leaks, since the first window only follows pixel 10 of frame 2.
5. conf_refresh mid-frame (after pixel 6), then a fresh 5x3 frame with 1x1 kernel, stride 1 -> 15 windows, each equal to its pixel; the pixel offered during the conf_refresh cycle is not accepted.
6. rst driven to 0 asynchronously mid-frame -> window_valid, frame_done and pixel_ready's stall path clear immediately; the subsequent frame behaves as in test 1.
